// File: rtl/vscpu_virq.sv
// Minimal accumulator-free CPU (VSCPU) with a vectored, edge-triggered,
// non-nesting interrupt unit. Memory is synchronous: read data returns one cycle after the address.
module vscpu_virq #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 14,
    parameter int unsigned NIRQ      = 4,
    parameter int unsigned VEC_BASE  = 8,
    parameter int unsigned SAVE_ADDR = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic [DW-1:0]   data_fromRAM,
    output logic            wrEn,
    output logic [AW-1:0]   addr_toRAM,
    output logic [DW-1:0]   data_toRAM,
    output logic            in_isr,
    output logic [NIRQ-1:0] irq_ack
);

    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_ADD  = 3'b000;
    localparam logic [OPW-1:0] OP_NAND = 3'b001;
    localparam logic [OPW-1:0] OP_SRL  = 3'b010;
    localparam logic [OPW-1:0] OP_LT   = 3'b011;
    localparam logic [OPW-1:0] OP_CP   = 3'b100;
    localparam logic [OPW-1:0] OP_BZJ  = 3'b110;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READB,
        S_EXEC,
        S_IRQ_VEC,
        S_IRQ_SAVE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   iw_q, iw_d;
    logic [DW-1:0]   opa_q, opa_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] ack_q, ack_d;
    logic            in_isr_q, in_isr_d;

    logic [NIRQ-1:0] irq_rise;
    logic [NIRQ-1:0] vec_sel;
    logic [NIRQ-1:0] pend_clr;
    logic [AW-1:0]   vec_idx;

    logic [DW-1:0]   cur_iw;
    logic [OPW-1:0]  op;
    logic            imm;
    logic [AW-1:0]   fa;
    logic [AW-1:0]   fb;

    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic [DW-1:0]   alu_res;
    logic            is_wr;
    logic            reti;
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   br_tgt;
    logic            take_irq;

    // In DECODE the instruction word is still on the read bus, not yet in iw_q
    assign cur_iw = (state_q == S_DECODE) ? data_fromRAM : iw_q;
    assign op     = cur_iw[DW-1 -: OPW];
    assign imm    = cur_iw[DW-4];
    assign fa     = cur_iw[DW-5 -: AW];
    assign fb     = cur_iw[AW-1:0];

    assign irq_rise = irq & ~irq_q;
    assign in_isr   = in_isr_q;
    assign irq_ack  = ack_q;

    // Lowest-index pending line wins the vector
    always_comb begin
        vec_sel = '0;
        vec_idx = '0;
        for (int j = int'(NIRQ) - 1; j >= 0; j--) begin
            if (pend_q[j]) begin
                vec_sel = NIRQ'(1) << j;
                vec_idx = AW'(j);
            end
        end
    end

    // Execute datapath: immediate forms see *A on the bus in EXEC
    always_comb begin
        opa     = imm ? data_fromRAM : opa_q;
        opb     = imm ? DW'(fb) : data_fromRAM;
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = opa + opb;
            OP_NAND: alu_res = ~(opa & opb);
            OP_SRL:  alu_res = (opb < DW'(DW)) ? (opa >> opb) : '0;
            OP_LT:   alu_res = DW'(opa < opb);
            OP_CP:   alu_res = opb;
            default: alu_res = '0;
        endcase
        is_wr  = (op <= OP_CP);
        reti   = (op == OP_BZJ) && (fa == AW'(SAVE_ADDR));
        pc_inc = pc_q + AW'(1);
        if (imm) begin
            br_tgt = opa[AW-1:0] + fb;
        end else begin
            br_tgt = (opb == '0) ? opa[AW-1:0] : pc_inc;
        end
        take_irq = (pend_q != '0) && !(in_isr_q && !reti);
    end

    // Next-state and memory-bus logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iw_d       = iw_q;
        opa_d      = opa_q;
        in_isr_d   = in_isr_q;
        ack_d      = '0;
        pend_clr   = '0;
        wrEn       = 1'b0;
        addr_toRAM = '0;
        data_toRAM = '0;

        case (state_q)
            S_FETCH: begin
                addr_toRAM = pc_q;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                iw_d       = data_fromRAM;
                addr_toRAM = fa;
                state_d    = imm ? S_EXEC : S_READB;
            end
            S_READB: begin
                opa_d      = data_fromRAM;
                addr_toRAM = fb;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                if (is_wr) begin
                    wrEn       = 1'b1;
                    addr_toRAM = fa;
                    data_toRAM = alu_res;
                end
                pc_d = (op == OP_BZJ) ? br_tgt : pc_inc;
                if (reti) begin
                    in_isr_d = 1'b0;
                end
                state_d = take_irq ? S_IRQ_VEC : S_FETCH;
            end
            S_IRQ_VEC: begin
                addr_toRAM = AW'(VEC_BASE) + vec_idx;
                ack_d      = vec_sel;
                pend_clr   = vec_sel;
                in_isr_d   = 1'b1;
                state_d    = S_IRQ_SAVE;
            end
            S_IRQ_SAVE: begin
                wrEn       = 1'b1;
                addr_toRAM = AW'(SAVE_ADDR);
                data_toRAM = DW'(pc_q);
                pc_d       = data_fromRAM[AW-1:0];
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A new edge on the line being cleared keeps it pending
        pend_d = (pend_q & ~pend_clr) | irq_rise;

        if (rst) begin
            wrEn       = 1'b0;
            addr_toRAM = '0;
            data_toRAM = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            iw_q     <= '0;
            opa_q    <= '0;
            pend_q   <= '0;
            irq_q    <= '0;
            ack_q    <= '0;
            in_isr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            iw_q     <= iw_d;
            opa_q    <= opa_d;
            pend_q   <= pend_d;
            irq_q    <= irq;
            ack_q    <= ack_d;
            in_isr_q <= in_isr_d;
        end
    end

endmodule

// File: tb/tb_vscpu_virq.sv
// Directed bench for vscpu_virq: ALU/branch vectors, interrupt vectoring, nesting and reset abort.
module tb_vscpu_virq;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 14;
    localparam int unsigned NIRQ = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NIRQ-1:0] irq = '0;
    logic [DW-1:0]   data_fromRAM;
    logic            wrEn;
    logic [AW-1:0]   addr_toRAM;
    logic [DW-1:0]   data_toRAM;
    logic            in_isr;
    logic [NIRQ-1:0] irq_ack;

    logic            tb_we = 1'b0;
    logic [AW-1:0]   tb_a  = '0;
    logic [DW-1:0]   tb_d  = '0;
    logic [DW-1:0]   mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    vscpu_virq #(.DW(DW), .AW(AW), .NIRQ(NIRQ), .VEC_BASE(8), .SAVE_ADDR(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .data_fromRAM (data_fromRAM),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM),
        .in_isr       (in_isr),
        .irq_ack      (irq_ack)
    );

    always #5 clk = ~clk;

    // Synchronous RAM; bench loads take priority over CPU writes
    always @(posedge clk) begin
        if (tb_we) mem[tb_a] <= tb_d;
        else if (wrEn) mem[addr_toRAM] <= data_toRAM;
        data_fromRAM <= mem[addr_toRAM];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check($sformatf("%s.wrEn", tag), 64'(wrEn), 64'(we));
        check($sformatf("%s.addr", tag), 64'(addr_toRAM), 64'(a));
        check($sformatf("%s.data", tag), 64'(data_toRAM), 64'(d));
    endtask

    function automatic logic [DW-1:0] ins(input logic [2:0] op, input logic i,
                                          input int unsigned a, input int unsigned b);
        logic [31:0] av, bv;
        av = a;
        bv = b;
        return {op, i, av[AW-1:0], bv[AW-1:0]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        irq = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input int unsigned a, input logic [DW-1:0] d);
        tb_a  = AW'(a);
        tb_d  = d;
        tb_we = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Release reset; returns inside cycle 1 (FETCH of address 0)
    task automatic go();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        i;
        int unsigned b;
        logic [31:0] m20;
        logic [31:0] m21;
        logic        wr;
        logic [31:0] res;
    } alu_vec_t;

    typedef struct {
        logic        i;
        int unsigned b;
        logic [31:0] m30;
        logic [31:0] m31;
        int unsigned pc;
    } br_vec_t;

    alu_vec_t av [12];
    br_vec_t  bv [4];
    logic [DW-1:0] reti_w;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        av[0]  = '{3'b000, 1'b0, 21,     32'd5,          32'd7,          1'b1, 32'd12};
        av[1]  = '{3'b000, 1'b1, 1,      32'hFFFF_FFFF,  32'd0,          1'b1, 32'd0};
        av[2]  = '{3'b001, 1'b0, 21,     32'hF0F0_F0F0,  32'hFF00_FF00,  1'b1, 32'h0FFF_0FFF};
        av[3]  = '{3'b010, 1'b0, 21,     32'h80,         32'd4,          1'b1, 32'h8};
        av[4]  = '{3'b010, 1'b0, 21,     32'h80,         32'd32,         1'b1, 32'h0};
        av[5]  = '{3'b010, 1'b1, 3,      32'h80,         32'd0,          1'b1, 32'h10};
        av[6]  = '{3'b011, 1'b0, 21,     32'd3,          32'd5,          1'b1, 32'd1};
        av[7]  = '{3'b011, 1'b0, 21,     32'hFFFF_FFFF,  32'd5,          1'b1, 32'd0};
        av[8]  = '{3'b100, 1'b0, 21,     32'd9,          32'hDEAD_BEEF,  1'b1, 32'hDEAD_BEEF};
        av[9]  = '{3'b100, 1'b1, 'h1234, 32'd9,          32'd0,          1'b1, 32'h1234};
        av[10] = '{3'b101, 1'b0, 21,     32'd1,          32'd2,          1'b0, 32'd0};
        av[11] = '{3'b111, 1'b1, 5,      32'd1,          32'd2,          1'b0, 32'd0};

        bv[0] = '{1'b0, 31, 32'd100,    32'd0, 100};
        bv[1] = '{1'b0, 31, 32'd100,    32'd3, 1};
        bv[2] = '{1'b1, 5,  32'd100,    32'd0, 105};
        bv[3] = '{1'b1, 2,  32'h3FFF,   32'd0, 1};

        reti_w = ins(3'b110, 1'b1, 6, 0);

        // ALU / NOP vectors, A = 20
        for (int t = 0; t < 12; t++) begin
            do_reset();
            poke(0, ins(av[t].op, av[t].i, 20, av[t].b));
            poke(20, av[t].m20);
            poke(21, av[t].m21);
            if (t == 0) bus("rst.hold", 1'b0, '0, '0);
            go();
            if (t == 0) begin
                bus("rst.after", 1'b0, '0, '0);
                check("rst.in_isr", 64'(in_isr), 64'd0);
                check("rst.irq_ack", 64'(irq_ack), 64'd0);
            end
            adv(1);
            check($sformatf("alu%0d.decode.addr", t), 64'(addr_toRAM), 64'd20);
            if (!av[t].i) begin
                adv(1);
                check($sformatf("alu%0d.readb.addr", t), 64'(addr_toRAM), 64'd21);
            end
            adv(1);
            bus($sformatf("alu%0d.exec", t), av[t].wr, av[t].wr ? AW'(20) : AW'(0), av[t].res);
            adv(1);
            check($sformatf("alu%0d.next_pc", t), 64'(addr_toRAM), 64'd1);
        end

        // Branch vectors, A = 30
        for (int t = 0; t < 4; t++) begin
            do_reset();
            poke(0, ins(3'b110, bv[t].i, 30, bv[t].b));
            poke(30, bv[t].m30);
            poke(31, bv[t].m31);
            go();
            adv(bv[t].i ? 2 : 3);
            bus($sformatf("br%0d.exec", t), 1'b0, '0, '0);
            adv(1);
            check($sformatf("br%0d.pc", t), 64'(addr_toRAM), 64'(bv[t].pc));
        end

        // Interrupts: simultaneous lines, no nesting, set-wins on clear
        do_reset();
        poke(0, ins(3'b110, 1'b1, 40, 10));
        poke(40, 0);
        poke(8, 70);
        poke(9, 50);
        poke(10, ins(3'b000, 1'b0, 20, 30));
        poke(20, 5);
        poke(30, 32'hA000_0000);
        poke(31, reti_w);
        poke(50, reti_w);
        poke(70, reti_w);
        go();                                   // c1
        adv(3);                                 // c4
        check("irq.pc10", 64'(addr_toRAM), 64'd10);
        adv(1);                                 // c5
        irq = 4'b0110;
        adv(2);                                 // c7
        bus("irq.add", 1'b1, 14'd20, 32'hA000_0005);
        adv(1);                                 // c8
        bus("irq.vec1", 1'b0, 14'd9, '0);
        adv(1);                                 // c9
        bus("irq.save1", 1'b1, 14'd6, 32'd11);
        check("irq.ack1", 64'(irq_ack), 64'h2);
        check("irq.in_isr1", 64'(in_isr), 64'd1);
        adv(1);                                 // c10
        check("irq.isr1_pc", 64'(addr_toRAM), 64'd50);
        check("irq.ack1_off", 64'(irq_ack), 64'd0);
        adv(3);                                 // c13
        bus("irq.vec2", 1'b0, 14'd10, '0);
        check("irq.reti_clr", 64'(in_isr), 64'd0);
        adv(1);                                 // c14
        bus("irq.save2", 1'b1, 14'd6, 32'd11);
        check("irq.ack2", 64'(irq_ack), 64'h4);
        adv(1);                                 // c15
        check("irq.isr2_pc", 64'(addr_toRAM), 64'd30);
        adv(1);                                 // c16
        irq = 4'b0111;
        adv(3);                                 // c19
        check("nest.no_vec", 64'(addr_toRAM), 64'd31);
        check("nest.in_isr", 64'(in_isr), 64'd1);
        irq = 4'b0110;
        adv(3);                                 // c22
        bus("nest.vec0", 1'b0, 14'd8, '0);
        irq = 4'b0111;
        adv(1);                                 // c23
        bus("nest.save0", 1'b1, 14'd6, 32'd11);
        check("nest.ack0", 64'(irq_ack), 64'h1);
        adv(1);                                 // c24
        check("nest.isr0_pc", 64'(addr_toRAM), 64'd70);
        adv(3);                                 // c27
        bus("setwin.vec0", 1'b0, 14'd8, '0);
        adv(1);                                 // c28
        check("setwin.ack0", 64'(irq_ack), 64'h1);
        adv(4);                                 // c32
        check("setwin.ret_pc", 64'(addr_toRAM), 64'd11);
        check("setwin.in_isr", 64'(in_isr), 64'd0);

        // Reset during READB aborts the ADD and drops a pending line
        do_reset();
        poke(0, ins(3'b000, 1'b0, 20, 21));
        poke(20, 5);
        poke(21, 7);
        go();                                   // c1
        irq = 4'b1000;
        adv(2);                                 // c3
        check("abort.readb", 64'(addr_toRAM), 64'd21);
        rst = 1'b1;
        #1;
        bus("abort.rst_cycle", 1'b0, '0, '0);
        adv(1);
        bus("abort.rst_hold", 1'b0, '0, '0);
        irq = '0;
        go();                                   // c1
        check("abort.pc0", 64'(addr_toRAM), 64'd0);
        adv(3);                                 // c4
        bus("abort.rerun", 1'b1, 14'd20, 32'd12);
        adv(1);                                 // c5
        check("abort.no_pend", 64'(addr_toRAM), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vscpu_virq.md
VSCPU_VIRQ -- requirements
Module: vscpu_virq

Interface
REQ-001 The block SHALL take parameter DW, default 32, meaning data and instruction word width; DW SHALL be at least 4+2*AW.
REQ-002 The block SHALL take parameter AW, default 14, meaning memory word-address width.
REQ-003 The block SHALL take parameter NIRQ, default 4, meaning the number of interrupt request lines, 1..16.
REQ-004 The block SHALL take parameter VEC_BASE, default 8, meaning the address of the vector table; entry i is at VEC_BASE+i.
REQ-005 The block SHALL take parameter SAVE_ADDR, default 6, meaning the address where the return PC is stored.
REQ-006 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port irq, input, NIRQ bits: interrupt requests, rising-edge sensitive.
REQ-009 The block SHALL have port data_fromRAM, input, DW bits: read data for the address presented in the previous cycle.
REQ-010 The block SHALL have port wrEn, output, 1 bit: memory write strobe.
REQ-011 The block SHALL have port addr_toRAM, output, AW bits: memory address.
REQ-012 The block SHALL have port data_toRAM, output, DW bits: write data.
REQ-013 The block SHALL have port in_isr, output, 1 bit: an interrupt service routine is active.
REQ-014 The block SHALL have port irq_ack, output, NIRQ bits: one-cycle pulse on the line being vectored.

Function
REQ-015 The instruction fields SHALL be: op = IW[DW-1:DW-3], i = IW[DW-4], A = IW[DW-5:DW-4-AW], B = IW[AW-1:0]; *X denotes mem[X].
REQ-016 The operations SHALL be as follows; i selects operand B instead of *B, with B zero-extended:
- op 000 ADD: *A <- *A + *B.
- op 001 NAND: *A <- ~(*A & *B).
- op 010 SRL: *A <- *A >> *B when *B < DW, else 0.
- op 011 LT: *A <- 1 when *A < *B (unsigned), else 0.
- op 100 CP: *A <- *B.
- op 110 BZJ: PC <- *A when *B == 0, else PC+1.
- op 110 with i=1, BZJi: PC <- *A + B.
REQ-017 Opcodes 101 and 111 SHALL execute as NOP: no write, PC <- PC+1.
REQ-018 All arithmetic SHALL be modulo 2^DW; PC arithmetic, including PC+1 and BZJi targets, SHALL wrap modulo 2^AW.
REQ-019 The state machine SHALL have states FETCH, DECODE, READB, EXEC, IRQ_VEC and IRQ_SAVE.
REQ-020 FETCH SHALL drive addr_toRAM=PC and then go to DECODE.
REQ-021 DECODE SHALL latch IW and drive addr=A.
- Non-immediate forms then go to READB.
- Immediate forms then go to EXEC, except CPi, which writes in DECODE+1.
REQ-022 READB SHALL latch *A and drive addr=B.
REQ-023 EXEC SHALL perform the write or branch: wrEn=1, addr=A, data=result for writing ops.
REQ-024 Latency SHALL be 4 cycles for register forms and 3 cycles for immediate forms and CPi.
REQ-025 A rising edge on irq[k], detected against a registered copy, SHALL set pending[k]; an edge on an already-pending line SHALL have no further effect.
REQ-026 At instruction end, when pending != 0 and in_isr = 0, the next state SHALL be IRQ_VEC instead of FETCH.
REQ-027 IRQ_VEC SHALL select k = the lowest-index pending bit and drive addr=VEC_BASE+k (mod 2^AW).
- It SHALL pulse irq_ack[k] for one cycle, clear pending[k] and set in_isr.
REQ-028 If a new edge on line k coincides with the clear of pending[k], the set SHALL win.
REQ-029 IRQ_SAVE SHALL write the next PC to SAVE_ADDR (wrEn=1, data zero-extended) and load PC <- data_fromRAM[AW-1:0], then go to FETCH.
REQ-030 A BZJ whose A == SAVE_ADDR SHALL be treated as return-from-interrupt: it SHALL clear in_isr at EXEC, and pending interrupts SHALL then be taken at that instruction end.
REQ-031 Interrupts SHALL NOT nest; edges arriving while in_isr = 1 SHALL stay pending.
REQ-032 wrEn SHALL be 0 in every state and case not listed above; addr_toRAM and data_toRAM SHALL be 0 when unused.

Reset
REQ-033 While rst is high, the block SHALL set state to FETCH and clear PC, IW, the operand register, pending, the irq history, in_isr and irq_ack.
REQ-034 In the cycle after reset, outputs SHALL be wrEn=0, addr_toRAM=0 and data_toRAM=0.
REQ-035 Reset asserted mid-instruction SHALL abort it with no write issued in the reset cycle.

Verification
REQ-036 ADD test: mem0 = ADD A=20 B=21, mem20=5, mem21=7 -> write 12 to address 20 in cycle 4, then PC=1 and FETCH.
REQ-037 Immediate wrap test: ADDi A=20 B=1 with mem20=0xFFFFFFFF -> write 0 to address 20 in cycle 3.
REQ-038 Branch test: BZJ A=30 B=31 with mem30=100 and mem31=0 -> PC=100; with mem31=3 -> PC=PC+1.
REQ-039 Simultaneous-interrupt test: irq[2] and irq[1] rise in the same cycle during an ADD at PC=10 ->
- After the write: irq_ack[1] pulses, address 6 is written with 11, and PC = mem[9].
- After the RETI, line 2 is serviced.
REQ-040 Nesting and reset test: an irq[0] edge while in_isr=1 -> not vectored until RETI; rst asserted during READB -> no write, PC=0, pending=0.
